// File: rtl/fft_bin_magnitude.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fft_bin_magnitude
// Description : Captures the first half of a completed FFT bin array, then
//               computes an alpha-max/beta-min magnitude per bin (one bin per
//               cycle), converts each to a saturated bar height and tracks
//               the strongest non-DC bin.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bin_magnitude #(
    parameter int WIDTH     = 32,
    parameter int SAMPLES   = 16,
    parameter int BAR_WIDTH = 8,
    parameter int SHIFT     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fft_valid,
    input  logic [WIDTH-1:0]             fft_bins [SAMPLES-1:0],
    output logic                         busy,
    output logic                         bars_valid,
    output logic [BAR_WIDTH-1:0]         bars [SAMPLES/2-1:0],
    output logic [$clog2(SAMPLES)-1:0]   peak_bin,
    output logic [WIDTH/2-1:0]           peak_mag
);

    localparam int c_half     = WIDTH / 2;
    localparam int c_num_bins = SAMPLES / 2;
    localparam int c_cnt_w    = $clog2(c_num_bins);
    localparam int c_sw       = (c_half > BAR_WIDTH) ? c_half : BAR_WIDTH;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_num_bins - 1);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
    localparam logic [c_sw-1:0]    c_bar_max = {c_sw{1'b1}} >> (c_sw - BAR_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nx;
    logic                   r_armed;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [WIDTH-1:0]       r_bins [c_num_bins];
    logic [c_half-1:0]      r_pk_mag;
    logic [c_cnt_w-1:0]     r_pk_idx;

    logic                   w_trigger;
    logic                   w_last;
    logic [WIDTH-1:0]       w_cur;
    logic [c_half-1:0]      w_re_abs;
    logic [c_half-1:0]      w_im_abs;
    logic [c_half-1:0]      w_a;
    logic [c_half-1:0]      w_b;
    logic [c_half:0]        w_sum;
    logic [c_half-1:0]      w_mag;
    logic [c_sw-1:0]        w_shift_ext;
    logic [BAR_WIDTH-1:0]   w_bar;
    logic                   w_take;
    logic [c_half-1:0]      w_pk_mag_nx;
    logic [c_cnt_w-1:0]     w_pk_idx_nx;

    // Absolute value where the most negative code maps to the largest positive one
    function automatic logic [c_half-1:0] sat_abs(input logic [c_half-1:0] v);
        logic [c_half-1:0] r;
        if (v == {1'b1, {(c_half-1){1'b0}}}) begin
            r = {1'b0, {(c_half-1){1'b1}}};
        end else if (v[c_half-1]) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Upper-half bins mirror the lower half for real input and are never captured
    logic [SAMPLES-c_num_bins-1:0] w_unused_hi;
    generate
        for (genvar k = 0; k < SAMPLES - c_num_bins; k++) begin : g_unused_hi
            assign w_unused_hi[k] = ^fft_bins[k + c_num_bins];
        end
    endgenerate

    assign w_trigger  = (r_state == S_IDLE) && r_armed && fft_valid;
    assign w_last     = (r_cnt == c_last);
    assign busy       = (r_state == S_CALC);
    assign bars_valid = (r_state == S_DONE);

    // Magnitude approximation max + min/2, bar scaling and running-peak update
    always_comb begin
        w_cur       = r_bins[r_cnt];
        w_re_abs    = sat_abs(w_cur[WIDTH-1:c_half]);
        w_im_abs    = sat_abs(w_cur[c_half-1:0]);
        w_a         = (w_re_abs > w_im_abs) ? w_re_abs : w_im_abs;
        w_b         = (w_re_abs > w_im_abs) ? w_im_abs : w_re_abs;
        w_sum       = {1'b0, w_a} + ({1'b0, w_b} >> 1);
        w_mag       = w_sum[c_half] ? {c_half{1'b1}} : w_sum[c_half-1:0];
        w_shift_ext = c_sw'(w_mag >> SHIFT);
        w_bar       = (w_shift_ext > c_bar_max) ? c_bar_max[BAR_WIDTH-1:0]
                                                : w_shift_ext[BAR_WIDTH-1:0];
        w_take      = (r_cnt != '0) && ((r_cnt == c_one) || (w_mag > r_pk_mag));
        w_pk_mag_nx = w_take ? w_mag : r_pk_mag;
        w_pk_idx_nx = w_take ? r_cnt : r_pk_idx;
    end

    // Next-state logic: IDLE -> CALC on trigger, CALC -> DONE after last bin
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_state_nx = S_CALC;
            S_CALC:  if (w_last)    w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Arming, capture, per-bin bar writes and peak publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed  <= 1'b0;
            r_cnt    <= '0;
            r_pk_mag <= '0;
            r_pk_idx <= '0;
            peak_bin <= '0;
            peak_mag <= '0;
            for (int k = 0; k < c_num_bins; k++) begin
                r_bins[k] <= '0;
                bars[k]   <= '0;
            end
        end else begin
            // A low fft_valid re-arms; the trigger consumes the arm
            if (!fft_valid) begin
                r_armed <= 1'b1;
            end else if (w_trigger) begin
                r_armed <= 1'b0;
            end

            if (w_trigger) begin
                r_cnt <= '0;
                for (int k = 0; k < c_num_bins; k++) begin
                    r_bins[k] <= fft_bins[k];
                end
            end

            if (r_state == S_CALC) begin
                bars[r_cnt] <= w_bar;
                r_pk_mag    <= w_pk_mag_nx;
                r_pk_idx    <= w_pk_idx_nx;
                r_cnt       <= r_cnt + c_one;
                if (w_last) begin
                    peak_bin <= {1'b0, w_pk_idx_nx};
                    peak_mag <= w_pk_mag_nx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fft_bin_magnitude.md
Name: fft_bin_magnitude

Overview:
- Downstream stage of the sequential N-point FFT. Consumes the completed complex frequency-bin array when the FFT asserts its valid flag.
- Computes an approximate magnitude for each unique bin, one bin per cycle, and converts each magnitude to a saturated bar height for the visualiser.
- Also reports the strongest non-DC bin.

Parameters:
- WIDTH, 32: bits per complex bin. Packed as {re[WIDTH-1:WIDTH/2], im[WIDTH/2-1:0]}, both two's-complement; C = WIDTH/2.
- SAMPLES, 16: FFT size, a power of 2 and at least 4. H = SAMPLES/2 unique bins are processed.
- BAR_WIDTH, 8: bits per bar height.
- SHIFT, 4: right-shift applied to the magnitude before saturation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- fft_valid  input  1  level flag from the FFT; high while the bin array is valid.
- fft_bins  input  WIDTH x SAMPLES (unpacked array [SAMPLES-1:0])  complex FFT bins.
- busy  output  1  high while capturing or computing.
- bars_valid  output  1  one-cycle pulse when a new bars/peak set is available.
- bars  output  BAR_WIDTH x H (unpacked array [H-1:0])  bar height per bin 0..H-1.
- peak_bin  output  $clog2(SAMPLES)  index of the largest-magnitude bin in 1..H-1.
- peak_mag  output  C  unsigned magnitude of peak_bin.

Behaviour:
- Reset: all outputs 0. State goes to IDLE, bin counter 0, armed=0, capture registers 0. Reset aborts any frame in progress; no bars_valid is issued for that frame.
- Arming: armed is set on any cycle with fft_valid=0, in any state. A trigger occurs in IDLE when armed=1 and fft_valid=1; the trigger clears armed. A fft_valid held high therefore yields exactly one frame.
- A fft_valid low-then-high sequence while busy leaves armed=1. The frame is then taken on the first IDLE cycle, using fft_bins as presented on that cycle.
- States:
  - IDLE: waits for a trigger. On the trigger edge it captures fft_bins[0..H-1] into registers and moves to CALC; busy goes to 1.
  - CALC: processes bin index i (0..H-1), one per cycle.
    - Compute |re|, |im|. An input of -2^(C-1) saturates to 2^(C-1)-1.
    - a = max, b = min; mag = a + (b>>1). Computed at C+1 bits, then clamped to 2^C-1.
    - bars[i] <= min(mag>>SHIFT, 2^BAR_WIDTH-1).
    - For i>=1: if mag > running peak, or i==1, then peak <= mag and idx <= i. Strict ">" means ties keep the lowest index.
    - After i=H-1, go to DONE.
  - DONE: bars_valid=1 for one cycle; peak_bin and peak_mag are updated; busy goes to 0; go to IDLE.
- Latency: trigger on cycle T, CALC on cycles T+1..T+H, bars_valid on cycle T+1+H (T+9 for SAMPLES=16).
- bars, peak_bin and peak_mag hold their values until the next DONE or reset.
- bars entries update progressively during CALC and are guaranteed coherent only when bars_valid=1 and afterwards.
- An all-zero frame gives bars all 0, peak_bin=1, peak_mag=0.
- fft_bins is sampled only on the trigger cycle; later changes have no effect on the current frame.

Test Plan:
(SAMPLES=16, WIDTH=32, BAR_WIDTH=8, SHIFT=4)
1. Single tone: bin3 = re 1600, im 0; other bins 0; trigger at T. Required: busy=1 on T+1..T+8, bars_valid pulse only at T+9, bars[3]=100 and all other bars 0, peak_bin=3, peak_mag=1600.
2. Approximation and tie: bin2 = bin6 = (re -300, im 400). Required: mag=550, bars[2]=bars[6]=34, peak_bin=2, peak_mag=550.
3. Saturation and DC exclusion: bin0 = (-32768, -32768), bin5 = (100, 0). Required: bars[0]=255 (mag 49150 clamped to 65535 is unaffected; 49150>>4=3071 saturates), peak_bin=5, peak_mag=100.
4. Level handling: hold fft_valid high for 40 cycles. Required: exactly one bars_valid pulse. Then drop fft_valid for 1 cycle and raise it again. Required: a second pulse 9 cycles after the new trigger.
5. Reset mid-frame: assert rst at T+4 for one cycle. Required: the next cycle has busy=0, bars all 0, peak 0, and no bars_valid. A subsequent low-then-high fft_valid produces a normal frame.
6. Deferred frame: toggle fft_valid low then high at T+3, while busy. Required: a second trigger on the first IDLE cycle (T+10) and a second bars_valid at T+19, using the bins present at T+10.
